// File: rtl/walnut_pkg.sv
// Shared definitions for the walnut plant tile controller: state encoding,
// lawn geometry limits and the pixel-coordinate helper.
package walnut_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ALIVE = 2'd1,
      BLINK = 2'd2
   } walnut_state_t;

   localparam int LAWN_ROWS = 5;
   localparam int LAWN_COLS = 9;
   localparam int PIX_W     = 10;

   // Cell origin in pixels; the result wraps to PIX_W bits like the renderer inputs.
   function automatic logic [PIX_W-1:0] cell_pix(input logic [PIX_W-1:0] origin,
                                                 input logic [PIX_W-1:0] pitch,
                                                 input logic [PIX_W-1:0] idx);
      return origin + idx * pitch;
   endfunction

endpackage

// File: rtl/walnut_frame_timer.sv
// Frame-tick counter with a run-time terminal value and synchronous clear.
// o_wrap flags the tick that lands on the terminal count; the counter then restarts at 0.
module walnut_frame_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clear,
   input  logic         i_tick,
   input  logic [W-1:0] i_last,
   output logic         o_wrap
);

   logic [W-1:0] r_count;

   assign o_wrap = i_tick && !i_clear && (r_count == i_last);

   // NOTE: sequential state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear || o_wrap) begin
         r_count <= '0;
      end else if (i_tick) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/walnut_ctrl.sv
// Lifecycle controller for one walnut tile: placement, health, eye-blink timing.
// Optional health regeneration is built when WALNUT_REGEN_EN is defined.
module walnut_ctrl
   import walnut_pkg::*;
#(
   parameter int               MAX_HP       = 72,
   parameter int               HP_W         = 7,
   parameter int               BLINK_PERIOD = 120,
   parameter int               BLINK_LEN    = 8,
   parameter int               REGEN_FRAMES = 180,
   parameter logic [PIX_W-1:0] GRID_X0      = 10'd40,
   parameter logic [PIX_W-1:0] GRID_Y0      = 10'd80,
   parameter logic [PIX_W-1:0] CELL_W       = 10'd80,
   parameter logic [PIX_W-1:0] CELL_H       = 10'd96
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_tick,
   input  logic             place_req,
   input  logic [2:0]       place_row,
   input  logic [3:0]       place_col,
   input  logic             bite,
   output logic             enable,
   output logic             blink,
   output logic [PIX_W-1:0] wVPos,
   output logic [PIX_W-1:0] wHPos,
   output logic [HP_W-1:0]  health,
   output logic             placed_ack,
   output logic             destroyed
);

   localparam int BLINK_MAX = (BLINK_PERIOD > BLINK_LEN) ? BLINK_PERIOD : BLINK_LEN;
   localparam int BLINK_W   = $clog2(BLINK_MAX + 1);

   walnut_state_t    r_state;
   logic             r_enable;
   logic             r_blink;
   logic [PIX_W-1:0] r_vpos;
   logic [PIX_W-1:0] r_hpos;
   logic [HP_W-1:0]  r_health;
   logic             r_placed_ack;
   logic             r_destroyed;

   logic               w_empty;
   logic               w_in_range;
   logic               w_kill;
   logic               w_blink_wrap;
   logic               w_regen_wrap;
   logic [BLINK_W-1:0] w_blink_last;

   assign w_empty      = (r_state == EMPTY);
   assign w_in_range   = (int'(place_row) < LAWN_ROWS) && (int'(place_col) < LAWN_COLS);
   assign w_kill       = !w_empty && bite && (r_health == HP_W'(1));
   assign w_blink_last = (r_state == BLINK) ? BLINK_W'(BLINK_LEN - 1)
                                            : BLINK_W'(BLINK_PERIOD - 1);

   // A killing bite clears the timer so a coincident tick cannot advance it.
   walnut_frame_timer #(.W(BLINK_W)) u_blink_timer (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_empty || w_kill),
      .i_tick  (frame_tick),
      .i_last  (w_blink_last),
      .o_wrap  (w_blink_wrap)
   );

`ifdef WALNUT_REGEN_EN
   localparam int REGEN_W = $clog2(REGEN_FRAMES + 1);

   walnut_frame_timer #(.W(REGEN_W)) u_regen_timer (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_empty || bite),
      .i_tick  (frame_tick),
      .i_last  (REGEN_W'(REGEN_FRAMES - 1)),
      .o_wrap  (w_regen_wrap)
   );
`else
   assign w_regen_wrap = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= EMPTY;
         r_enable     <= 1'b0;
         r_blink      <= 1'b0;
         r_vpos       <= '0;
         r_hpos       <= '0;
         r_health     <= '0;
         r_placed_ack <= 1'b0;
         r_destroyed  <= 1'b0;
      end else begin
         r_placed_ack <= 1'b0;
         r_destroyed  <= 1'b0;
         unique case (r_state)
            EMPTY: begin
               if (place_req && w_in_range) begin
                  r_state      <= ALIVE;
                  r_enable     <= 1'b1;
                  r_blink      <= 1'b0;
                  r_vpos       <= cell_pix(GRID_Y0, CELL_H, PIX_W'(place_row));
                  r_hpos       <= cell_pix(GRID_X0, CELL_W, PIX_W'(place_col));
                  r_health     <= HP_W'(MAX_HP);
                  r_placed_ack <= 1'b1;
               end
            end
            ALIVE, BLINK: begin
               if (w_kill) begin
                  r_state     <= EMPTY;
                  r_enable    <= 1'b0;
                  r_blink     <= 1'b0;
                  r_health    <= '0;
                  r_destroyed <= 1'b1;
               end else begin
                  if (bite) begin
                     r_health <= r_health - 1'b1;
                  end else if (w_regen_wrap && (r_health < HP_W'(MAX_HP))) begin
                     r_health <= r_health + 1'b1;
                  end
                  if (w_blink_wrap) begin
                     r_state <= (r_state == ALIVE) ? BLINK : ALIVE;
                     r_blink <= (r_state == ALIVE);
                  end
               end
            end
            default: begin
               r_state  <= EMPTY;
               r_enable <= 1'b0;
               r_blink  <= 1'b0;
            end
         endcase
      end
   end

   assign enable     = r_enable;
   assign blink      = r_blink;
   assign wVPos      = r_vpos;
   assign wHPos      = r_hpos;
   assign health     = r_health;
   assign placed_ack = r_placed_ack;
   assign destroyed  = r_destroyed;

endmodule
